aha_pwr_seq_ctrl: RTL and testbench



---
 rtl/aha_pwr_seq_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_aha_pwr_seq_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/aha_pwr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// aha_pwr_seq_ctrl
//
// Power/clock sequencer for one gated subsystem. A power request, already
// reduced to single-cycle REQ_RISE / REQ_FALL pulses in the CLK domain, is
// folded into a request level. The FSM then walks the subsystem clock enable,
// reset and isolation through a fixed on/off order. A sequence, once started,
// always runs to completion. The request level is only acted on in ON or OFF.
//
// Parameters
//   CLK_SETTLE : clock cycles before reset release / after clock stop (1..255)
//   RST_HOLD   : cycles between reset and isolation edges            (1..255)
//
// Optional feature macro
//   AHA_PWR_SEQ_ISO_EN : when defined, the ISO_REL / ISO_SET steps exist and
//                        ISO_EN is driven. When undefined, ISO_EN is tied to 0
//                        and the sequence goes RST_REL -> ON -> RST_SET.
//
// Ports
//   CLK        in  : controller clock
//   RESETn     in  : synchronous active-low reset
//   REQ_RISE   in  : power-up request pulse
//   REQ_FALL   in  : power-down request pulse
//   CLK_EN     out : subsystem clock-gate enable
//   SUB_RESETn out : subsystem reset, active-low
//   ISO_EN     out : subsystem output isolation, active-high
//   ACK        out : high only in ON
//   BUSY       out : high in every state except OFF and ON
// -----------------------------------------------------------------------------
module aha_pwr_seq_ctrl #(
  parameter int unsigned CLK_SETTLE = 4,
  parameter int unsigned RST_HOLD   = 8
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic REQ_RISE,
  input  logic REQ_FALL,
  output logic CLK_EN,
  output logic SUB_RESETn,
  output logic ISO_EN,
  output logic ACK,
  output logic BUSY
);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_CLK_START = 3'd1,
    ST_RST_REL   = 3'd2,
    ST_ISO_REL   = 3'd3,
    ST_ON        = 3'd4,
    ST_ISO_SET   = 3'd5,
    ST_RST_SET   = 3'd6,
    ST_CLK_STOP  = 3'd7
  } state_t;

  // Wait states are entered with (length - 1) and exit when the counter is 0.
  localparam logic [7:0] SETTLE_LD = 8'(CLK_SETTLE - 1);
  localparam logic [7:0] HOLD_LD   = 8'(RST_HOLD - 1);

`ifdef AHA_PWR_SEQ_ISO_EN
  localparam logic ISO_RST = 1'b1;
`else
  localparam logic ISO_RST = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req_level_q, req_next;
  logic       clk_en_q, clk_en_d;
  logic       sub_rstn_q, sub_rstn_d;
  logic       iso_en_q, iso_en_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;

  // Request level: a lone pulse sets/clears it, simultaneous pulses hold it.
  always_comb begin
    req_next = req_level_q;
    if (REQ_RISE && !REQ_FALL) begin
      req_next = 1'b1;
    end else if (REQ_FALL && !REQ_RISE) begin
      req_next = 1'b0;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (req_next) begin
          state_d = ST_CLK_START;
          cnt_d   = SETTLE_LD;
        end
      end
      ST_CLK_START: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_RST_REL;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RST_REL: begin
        if (cnt_q == 8'd0) begin
`ifdef AHA_PWR_SEQ_ISO_EN
          state_d = ST_ISO_REL;
`else
          state_d = ST_ON;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`ifdef AHA_PWR_SEQ_ISO_EN
      ST_ISO_REL: begin
        state_d = ST_ON;
      end
`endif
      ST_ON: begin
        if (!req_next) begin
`ifdef AHA_PWR_SEQ_ISO_EN
          state_d = ST_ISO_SET;
`else
          state_d = ST_RST_SET;
          cnt_d   = HOLD_LD;
`endif
        end
      end
`ifdef AHA_PWR_SEQ_ISO_EN
      ST_ISO_SET: begin
        state_d = ST_RST_SET;
        cnt_d   = HOLD_LD;
      end
`endif
      ST_RST_SET: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_CLK_STOP;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_CLK_STOP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state register and can never glitch.
  always_comb begin
    clk_en_d   = 1'b0;
    sub_rstn_d = 1'b0;
    iso_en_d   = ISO_RST;
    ack_d      = 1'b0;
    busy_d     = 1'b1;
    case (state_d)
      ST_OFF:       begin busy_d = 1'b0; end
      ST_CLK_START: begin clk_en_d = 1'b1; end
      ST_RST_REL:   begin clk_en_d = 1'b1; sub_rstn_d = 1'b1; end
      ST_ISO_REL:   begin clk_en_d = 1'b1; sub_rstn_d = 1'b1; iso_en_d = 1'b0; end
      ST_ON: begin
        clk_en_d   = 1'b1;
        sub_rstn_d = 1'b1;
        iso_en_d   = 1'b0;
        ack_d      = 1'b1;
        busy_d     = 1'b0;
      end
      ST_ISO_SET:   begin clk_en_d = 1'b1; sub_rstn_d = 1'b1; end
      ST_RST_SET:   begin clk_en_d = 1'b1; end
      ST_CLK_STOP:  begin end
      default:      begin busy_d = 1'b0; end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q     <= ST_OFF;
      cnt_q       <= 8'd0;
      req_level_q <= 1'b0;
      clk_en_q    <= 1'b0;
      sub_rstn_q  <= 1'b0;
      iso_en_q    <= ISO_RST;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_level_q <= req_next;
      clk_en_q    <= clk_en_d;
      sub_rstn_q  <= sub_rstn_d;
      iso_en_q    <= iso_en_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  assign CLK_EN     = clk_en_q;
  assign SUB_RESETn = sub_rstn_q;
  assign ISO_EN     = iso_en_q;
  assign ACK        = ack_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_aha_pwr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aha_pwr_seq_ctrl
//
// Scoreboard bench for aha_pwr_seq_ctrl at default parameters. The stimulus
// process drives one cycle at a time and runs a timeline model: each power
// sequence is described by its start cycle and the offsets at which each
// output changes. It pushes the expected outputs for the following cycle
// into a queue. A separate monitor pops one entry per cycle and compares it
// with the DUT outputs. Honours AHA_PWR_SEQ_ISO_EN like the design.
// -----------------------------------------------------------------------------
module tb_aha_pwr_seq_ctrl;

  localparam int CS = 4;
  localparam int RH = 8;
`ifdef AHA_PWR_SEQ_ISO_EN
  localparam int ISO_D = 1;
`else
  localparam int ISO_D = 0;
`endif
  // Cycle offsets (from the request cycle) at which ON / OFF are reached.
  localparam int T_ON  = 1 + CS + RH + ISO_D;
  localparam int T_OFF = 1 + ISO_D + RH + CS;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rise = 1'b0;
  logic fall = 1'b0;
  logic clk_en, sub_rstn, iso_en, ack, busy;

  always #5 clk = ~clk;

  aha_pwr_seq_ctrl #(
    .CLK_SETTLE (CS),
    .RST_HOLD   (RH)
  ) dut (
    .CLK        (clk),
    .RESETn     (rstn),
    .REQ_RISE   (rise),
    .REQ_FALL   (fall),
    .CLK_EN     (clk_en),
    .SUB_RESETn (sub_rstn),
    .ISO_EN     (iso_en),
    .ACK        (ack),
    .BUSY       (busy)
  );

  logic [4:0] exp_q[$];
  int         cyc_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cycle    = 0;

  // Model: phase 0 = idle off, 1 = powering up, 2 = idle on, 3 = powering
  // down. m_k counts cycles since the request that started the sequence.
  int m_phase = 0;
  int m_k     = 0;
  bit m_req   = 1'b0;

  function automatic logic [4:0] model_outs();
    logic ce, sr, iso, ak, bz;
    ce  = 1'b0;
    sr  = 1'b0;
    iso = (ISO_D == 1);
    ak  = 1'b0;
    bz  = 1'b0;
    case (m_phase)
      1: begin
        ce  = 1'b1;
        sr  = (m_k >= 1 + CS);
        iso = (ISO_D == 1) && (m_k < 1 + CS + RH);
        bz  = 1'b1;
      end
      2: begin
        ce  = 1'b1;
        sr  = 1'b1;
        iso = 1'b0;
        ak  = 1'b1;
      end
      3: begin
        ce  = (m_k < 1 + ISO_D + RH);
        sr  = (m_k < 1 + ISO_D);
        iso = (ISO_D == 1);
        bz  = 1'b1;
      end
      default: ;
    endcase
    return {ce, sr, iso, ak, bz};
  endfunction

  task automatic step(input bit r, input bit f, input bit rn);
    bit rq;
    @(negedge clk);
    rise = r;
    fall = f;
    rstn = rn;
    if (r || f || !rn)
      $display("txn cyc=%0d rise=%0d fall=%0d resetn=%0d", cycle, r, f, rn);
    if (!rn) begin
      m_phase = 0;
      m_k     = 0;
      m_req   = 1'b0;
    end else begin
      rq = m_req;
      if (r && !f) rq = 1'b1;
      else if (f && !r) rq = 1'b0;
      case (m_phase)
        0: if (rq) begin m_phase = 1; m_k = 1; end
        1: begin
          m_k++;
          if (m_k == T_ON) begin m_phase = 2; m_k = 0; end
        end
        2: if (!rq) begin m_phase = 3; m_k = 1; end
        default: begin
          m_k++;
          if (m_k == T_OFF) begin m_phase = 0; m_k = 0; end
        end
      endcase
      m_req = rq;
    end
    exp_q.push_back(model_outs());
    cyc_q.push_back(cycle + 1);
    cycle++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: one comparison per clock once expectations are queued.
  initial begin
    logic [4:0] e, got;
    int         c;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        c   = cyc_q.pop_front();
        got = {clk_en, sub_rstn, iso_en, ack, busy};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d {clk_en,sub_rstn,iso_en,ack,busy} got=%b exp=%b",
                   c, got, e);
        end
      end
    end
  end

  initial begin
    // Reset, with a pulse during reset that must be ignored.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    // Power-up, idle hold, power-down.
    step(1'b1, 1'b0, 1'b1); idle(20);
    step(1'b0, 1'b1, 1'b1); idle(20);
    // Quick request: rise at 0, fall at 3.
    step(1'b1, 1'b0, 1'b1); idle(2);
    step(1'b0, 1'b1, 1'b1); idle(35);
    // Both pulses while OFF, then while ON, plus a redundant rise while ON.
    step(1'b1, 1'b1, 1'b1); idle(5);
    step(1'b1, 1'b0, 1'b1); idle(20);
    step(1'b1, 1'b1, 1'b1); idle(3);
    step(1'b1, 1'b0, 1'b1); idle(5);
    step(1'b0, 1'b1, 1'b1); idle(20);
    // Redundant fall while OFF.
    step(1'b0, 1'b1, 1'b1); idle(3);
    // Reset in cycle 7 of a power-up, then restart.
    step(1'b1, 1'b0, 1'b1); idle(6);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1); idle(20);
    step(1'b0, 1'b1, 1'b1); idle(20);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 100) < 4, ($urandom % 100) < 4, ($urandom % 250) != 0);
    end
    idle(2);
    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
